// File: rtl/shift_register_ctrl_4_pkg.sv
// Shared encodings for the shift-register sequencer, the register it drives,
// and anything that wants to interpret s1/s0.
package shift_register_ctrl_4_pkg;

    // {s1,s0} mode select of the universal shift register
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_register_ctrl_4_if.sv
// Request/response bus between the lab top level (master) and the sequencer (slave).
interface shift_register_ctrl_4_if #(
    parameter int W     = 4,
    parameter int CNT_W = 2
);
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] nbits;
    logic [W-1:0]     data_in;
    logic             ser_in;
    logic             busy;
    logic             done;
    logic             ser_out;
    logic [W-1:0]     data_out;

    modport master (
        output start, dir, nbits, data_in, ser_in,
        input  busy, done, ser_out, data_out
    );

    modport slave (
        input  start, dir, nbits, data_in, ser_in,
        output busy, done, ser_out, data_out
    );
endinterface

// File: rtl/shift_register_ctrl_4_ureg.sv
// 4-bit universal shift register driven by the sequencer through s1/s0.
module shift_register_ctrl_4_ureg
    import shift_register_ctrl_4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         s1,
    input  logic         s0,
    input  logic [W-1:0] i_par,
    input  logic         msb_in,
    input  logic         lsb_in,
    output logic [W-1:0] a_par
);

    // Hold / shift right (fill at MSB) / shift left (fill at LSB) / parallel load
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            a_par <= '0;
        end else begin
            case ({s1, s0})
                MODE_SHR:  a_par <= {msb_in, a_par[W-1:1]};
                MODE_SHL:  a_par <= {a_par[W-2:0], lsb_in};
                MODE_LOAD: a_par <= i_par;
                default:   a_par <= a_par;
            endcase
        end
    end

endmodule

// File: rtl/shift_register_ctrl_4.sv
// Sequencer: loads a word into the external shift register, then shifts it
// N times, serializing out on ser_out while ser_in fills the vacated end.
module shift_register_ctrl_4
    import shift_register_ctrl_4_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   clear,
    shift_register_ctrl_4_if.slave bus,
    output logic                   s1,
    output logic                   s0,
    output logic [W-1:0]           reg_i_par,
    output logic                   reg_msb_in,
    output logic                   reg_lsb_in,
    input  logic [W-1:0]           reg_a_par
);

    state_t           state;
    logic             dir_q;
    logic [CNT_W-1:0] nbits_q;
    logic [W-1:0]     word_q;
    logic [W-1:0]     data_q;
    logic [CNT_W:0]   cnt;   // one extra bit so it can hold W
    logic [1:0]       mode;
    logic             ser_bit;
    logic [W-1:0]     data_view;

    // State, shift counter, latched request and held result
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= ST_IDLE;
            dir_q   <= 1'b0;
            nbits_q <= '0;
            word_q  <= '0;
            data_q  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        dir_q   <= bus.dir;
                        nbits_q <= bus.nbits;
                        word_q  <= bus.data_in;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // nbits==0 means a full-width transfer
                    cnt   <= (nbits_q == '0) ? (CNT_W+1)'(W) : {1'b0, nbits_q};
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == (CNT_W+1)'(1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // Register already holds the post-shift word; keep it for later
                    data_q <= reg_a_par;
                    if (bus.start) begin
                        dir_q   <= bus.dir;
                        nbits_q <= bus.nbits;
                        word_q  <= bus.data_in;
                        state   <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decode register controls and outputs from the current state
    always_comb begin
        mode      = MODE_HOLD;
        reg_i_par = '0;
        ser_bit   = 1'b0;
        data_view = data_q;
        case (state)
            ST_LOAD: begin
                mode      = MODE_LOAD;
                reg_i_par = word_q;
            end
            ST_SHIFT: begin
                mode    = dir_q ? MODE_SHL : MODE_SHR;
                ser_bit = dir_q ? reg_a_par[W-1] : reg_a_par[0];
            end
            ST_DONE: data_view = reg_a_par;   // result visible alongside done
            default: ;
        endcase
    end

    assign {s1, s0}     = mode;
    assign reg_msb_in   = bus.ser_in;
    assign reg_lsb_in   = bus.ser_in;
    assign bus.busy     = (state == ST_LOAD) || (state == ST_SHIFT);
    assign bus.done     = (state == ST_DONE);
    assign bus.ser_out  = ser_bit;
    assign bus.data_out = data_view;

endmodule
